// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM port scheduler: one scan-out fetch slot per 2^SCALE_LOG2 active pixels, with the remaining slots shared round-robin by two writers.
// Pixel and sync/blank outputs are realigned by 3 cycles. Optional macro FB_WR_BLANK_ONLY_EN restricts writes to vertical blanking.
module vga_fb_arbiter #(
  parameter int HACTIVE    = 640,
  parameter int VACTIVE    = 480,
  parameter int SCALE_LOG2 = 2,
  parameter int AW         = 15,
  parameter int DW         = 8
) (
  input  logic          vgaclk,
  input  logic          reset,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          blank_b,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          wr0_valid,
  output logic          wr0_ready,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  input  logic          wr1_valid,
  output logic          wr1_ready,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic [DW-1:0] pix,
  output logic          hsync_d,
  output logic          vsync_d,
  output logic          blank_b_d,
  output logic          wr_drop
);

  localparam int FB_W    = HACTIVE >> SCALE_LOG2;
  localparam int FB_H    = VACTIVE >> SCALE_LOG2;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam logic [9:0] SUB_MASK = 10'((1 << SCALE_LOG2) - 1);

  logic          fetch;
  logic          free_slot;
  logic [AW-1:0] fetch_addr;
  logic          gnt0, gnt1, grant;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          in_range;

  logic          ptr_q, ptr_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          wr_drop_q, wr_drop_d;
  logic [1:0]    tag_q, tag_d;
  logic [DW-1:0] pix_q, pix_d;
  logic [2:0]    hs_pipe_q, hs_pipe_d;
  logic [2:0]    vs_pipe_q, vs_pipe_d;
  logic [2:0]    bl_pipe_q, bl_pipe_d;

  assign fetch      = blank_b && ((x & SUB_MASK) == '0);
  assign fetch_addr = AW'(y >> SCALE_LOG2) * AW'(FB_W) + AW'(x >> SCALE_LOG2);

`ifdef FB_WR_BLANK_ONLY_EN
  // Writers only touch the framebuffer while no visible line is being scanned.
  assign free_slot = !reset && !fetch && (y >= 10'(VACTIVE));
`else
  assign free_slot = !reset && !fetch;
`endif

  // ptr_q names the preferred requester: 0 = wr0, 1 = wr1.
  assign gnt0  = free_slot && wr0_valid && (!wr1_valid || !ptr_q);
  assign gnt1  = free_slot && wr1_valid && (!wr0_valid ||  ptr_q);
  assign grant = gnt0 || gnt1;

  assign wr0_ready = gnt0;
  assign wr1_ready = gnt1;

  assign sel_addr = gnt1 ? wr1_addr : wr0_addr;
  assign sel_data = gnt1 ? wr1_data : wr0_data;
  assign in_range = {1'b0, sel_addr} < (AW+1)'(FB_SIZE);

  always_comb begin
    ptr_d       = ptr_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    wr_drop_d   = 1'b0;
    if (fetch) begin
      ram_addr_d = fetch_addr;
    end else if (grant) begin
      ptr_d = gnt0;
      if (in_range) begin
        ram_addr_d  = sel_addr;
        ram_wdata_d = sel_data;
        ram_we_d    = 1'b1;
      end else begin
        wr_drop_d = 1'b1;
      end
    end
  end

  // Read data returns two cycles after the fetch decision; the tag marks when to capture it.
  assign tag_d     = {tag_q[0], fetch};
  assign pix_d     = tag_q[1] ? ram_rdata : pix_q;
  assign hs_pipe_d = {hs_pipe_q[1:0], hsync};
  assign vs_pipe_d = {vs_pipe_q[1:0], vsync};
  assign bl_pipe_d = {bl_pipe_q[1:0], blank_b};

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      ptr_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wr_drop_q   <= 1'b0;
      tag_q       <= '0;
      pix_q       <= '0;
      hs_pipe_q   <= '1;
      vs_pipe_q   <= '1;
      bl_pipe_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      wr_drop_q   <= wr_drop_d;
      tag_q       <= tag_d;
      pix_q       <= pix_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      bl_pipe_q   <= bl_pipe_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign wr_drop   = wr_drop_q;
  assign hsync_d   = hs_pipe_q[2];
  assign vsync_d   = vs_pipe_q[2];
  assign blank_b_d = bl_pipe_q[2];
  assign pix       = blank_b_d ? pix_q : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a synchronous RAM model.
module tb_vga_fb_arbiter;

  logic        vgaclk;
  logic        reset;
  logic [9:0]  x, y;
  logic        hsync, vsync, blank_b;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [14:0] wr0_addr, wr1_addr;
  logic [7:0]  wr0_data, wr1_data;
  logic [7:0]  pix;
  logic        hsync_d, vsync_d, blank_b_d, wr_drop;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:32767];
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [7:0]  pre_dat;

  vga_fb_arbiter dut (
    .vgaclk(vgaclk), .reset(reset), .x(x), .y(y),
    .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .pix(pix), .hsync_d(hsync_d), .vsync_d(vsync_d), .blank_b_d(blank_b_d), .wr_drop(wr_drop)
  );

  initial vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  always @(posedge vgaclk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        bl;
    logic [9:0]  x, y;
    logic        v0, v1;
    logic [14:0] a0, a1;
    logic        r0, r1, we;
    logic [14:0] addr;
    logic [7:0]  wd;
    logic        ca, cw, drop;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic bl, input int xi, input int yi, input logic v0, input logic v1,
                              input int a0, input int a1, input logic r0, input logic r1, input logic we,
                              input int addr, input logic [7:0] wd, input logic ca, input logic cw,
                              input logic drop);
    vec_t v;
    v.bl = bl; v.x = 10'(xi); v.y = 10'(yi); v.v0 = v0; v.v1 = v1;
    v.a0 = 15'(a0); v.a1 = 15'(a1); v.r0 = r0; v.r1 = r1; v.we = we;
    v.addr = 15'(addr); v.wd = wd; v.ca = ca; v.cw = cw; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge vgaclk);
    #1;
  endtask

  task automatic drive(input logic bl, input int xi, input int yi);
    blank_b = bl;
    x = 10'(xi);
    y = 10'(yi);
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = 15'(a); pre_dat = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ram_addr"}, 32'(ram_addr), 0);
    chk({tag, " ram_we"}, 32'(ram_we), 0);
    chk({tag, " ram_wdata"}, 32'(ram_wdata), 0);
    chk({tag, " pix"}, 32'(pix), 0);
    chk({tag, " hsync_d"}, 32'(hsync_d), 1);
    chk({tag, " vsync_d"}, 32'(vsync_d), 1);
    chk({tag, " blank_b_d"}, 32'(blank_b_d), 0);
    chk({tag, " wr_drop"}, 32'(wr_drop), 0);
    chk({tag, " wr0_ready"}, 32'(wr0_ready), 0);
    chk({tag, " wr1_ready"}, 32'(wr1_ready), 0);
  endtask

  initial begin
    reset = 1'b1;
    x = '0; y = '0; hsync = 1'b1; vsync = 1'b1; blank_b = 1'b0;
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;

    tbl[0]  = mk(0, 700, 490, 1, 1,   100, 200, 1, 0, 1,   100, 8'h64, 1, 1, 0);
    tbl[1]  = mk(0, 701, 490, 1, 1,   101, 201, 0, 1, 1,   201, 8'h36, 1, 1, 0);
    tbl[2]  = mk(0, 702, 490, 1, 1,   102, 202, 1, 0, 1,   102, 8'h66, 1, 1, 0);
    tbl[3]  = mk(0, 703, 490, 1, 1,   103, 203, 0, 1, 1,   203, 8'h34, 1, 1, 0);
    tbl[4]  = mk(1,   4,   4, 1, 1,     0,   0, 0, 0, 0,   161, 8'h00, 1, 0, 0);
    tbl[5]  = mk(1,   5,   4, 1, 1,   104, 204, 1, 0, 1,   104, 8'h68, 1, 1, 0);
    tbl[6]  = mk(1,   6,   4, 1, 0,   105,   0, 1, 0, 1,   105, 8'h69, 1, 1, 0);
    tbl[7]  = mk(1,   7,   4, 1, 1,   106, 206, 0, 1, 1,   206, 8'h31, 1, 1, 0);
    tbl[8]  = mk(1, 636, 479, 1, 1,     0,   0, 0, 0, 0, 19199, 8'h00, 1, 0, 0);
    tbl[9]  = mk(1, 637, 479, 0, 1,     0, 207, 0, 1, 1,   207, 8'h30, 1, 1, 0);
    tbl[10] = mk(1, 638, 479, 0, 1,     0, 208, 0, 1, 1,   208, 8'h2F, 1, 1, 0);
    tbl[11] = mk(0, 650, 479, 0, 0,     0,   0, 0, 0, 0,   208, 8'h2F, 1, 1, 0);
    tbl[12] = mk(0, 651, 479, 1, 1, 19200, 300, 1, 0, 0,     0, 8'h00, 0, 0, 1);
    tbl[13] = mk(0, 652, 479, 1, 0, 19199,   0, 1, 0, 1, 19199, 8'hFF, 1, 1, 0);
    tbl[14] = mk(1,   0,   0, 1, 1,     0,   0, 0, 0, 0,     0, 8'h00, 1, 0, 0);

    tick();
    preload(160, 8'h11);
    preload(161, 8'h5A);
    preload(162, 8'h22);
    preload(163, 8'h44);
    preload(600, 8'h33);
    preload(19200, 8'hEE);
    check_reset_outputs("init");

    // Release reset at the first pixel of a frame.
    drive(1, 0, 0);
    reset = 1'b0;
    tick();
    chk("release ram_addr", 32'(ram_addr), 0);
    chk("release ram_we", 32'(ram_we), 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].bl, int'(tbl[i].x), int'(tbl[i].y));
      wr0_valid = tbl[i].v0; wr1_valid = tbl[i].v1;
      wr0_addr = tbl[i].a0;  wr1_addr = tbl[i].a1;
      wr0_data = tbl[i].a0[7:0];
      wr1_data = ~tbl[i].a1[7:0];
      #1;
      chk($sformatf("row%0d wr0_ready", i), 32'(wr0_ready), 32'(tbl[i].r0));
      chk($sformatf("row%0d wr1_ready", i), 32'(wr1_ready), 32'(tbl[i].r1));
      tick();
      chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(tbl[i].we));
      chk($sformatf("row%0d wr_drop", i), 32'(wr_drop), 32'(tbl[i].drop));
      if (tbl[i].ca) chk($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
      if (tbl[i].cw) chk($sformatf("row%0d ram_wdata", i), 32'(ram_wdata), 32'(tbl[i].wd));
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    chk("mem[100]", 32'(mem[100]), 32'h64);
    chk("mem[201]", 32'(mem[201]), 32'h36);
    chk("mem[19199]", 32'(mem[19199]), 32'hFF);
    chk("mem[19200] untouched", 32'(mem[19200]), 32'hEE);

    // Single writer holding valid across the x=8 fetch slot.
    drive(1, 8, 4);
    wr0_valid = 1'b1; wr0_addr = 15'd500; wr0_data = 8'h77;
    #1;
    chk("hold x8 wr0_ready", 32'(wr0_ready), 0);
    tick();
    drive(1, 9, 4);
    #1;
    chk("hold x9 wr0_ready", 32'(wr0_ready), 1);
    tick();
    wr0_valid = 1'b0;
    drive(1, 10, 4);
    chk("hold x10 ram_we", 32'(ram_we), 1);
    chk("hold x10 ram_addr", 32'(ram_addr), 500);
    chk("hold x10 ram_wdata", 32'(ram_wdata), 32'h77);
    tick();
    chk("mem[500]", 32'(mem[500]), 32'h77);

    // Writer arriving mid-frame: blank-only mode defers it to vertical blanking.
    wr1_valid = 1'b1; wr1_addr = 15'd700; wr1_data = 8'h01;
    drive(1, 0, 100);
    #1;
    chk("y100 x0 wr1_ready", 32'(wr1_ready), 0);
    tick();
    drive(1, 1, 100);
    #1;
`ifdef FB_WR_BLANK_ONLY_EN
    chk("y100 x1 wr1_ready", 32'(wr1_ready), 0);
`else
    chk("y100 x1 wr1_ready", 32'(wr1_ready), 1);
`endif
    tick();
    drive(0, 700, 100);
    #1;
`ifdef FB_WR_BLANK_ONLY_EN
    chk("y100 hblank wr1_ready", 32'(wr1_ready), 0);
`else
    chk("y100 hblank wr1_ready", 32'(wr1_ready), 1);
`endif
    tick();
    drive(0, 0, 480);
    #1;
    chk("y480 x0 wr1_ready", 32'(wr1_ready), 1);
    tick();
    wr1_valid = 1'b0;

    // Fetch pipeline and sync realignment over one line segment.
    for (int i = 0; i < 3; i++) begin
      drive(0, 700, 3);
      tick();
    end
    for (int c = 0; c < 16; c++) begin
      drive(1, c, 4);
      hsync = (c == 5) ? 1'b0 : 1'b1;
      #1;
      if (c == 2) begin
        chk("c2 blank_b_d", 32'(blank_b_d), 0);
        chk("c2 pix blanked", 32'(pix), 0);
      end
      if (c >= 3 && c <= 10) chk($sformatf("c%0d pix", c), 32'(pix), (c < 7) ? 32'h11 : 32'h5A);
      if (c >= 3) chk($sformatf("c%0d hsync_d", c), 32'(hsync_d), (c == 8) ? 0 : 1);
      tick();
    end

    // Reset asserted while a write is on the RAM port and another is being granted.
    hsync = 1'b0; vsync = 1'b0;
    drive(1, 17, 4); tick();
    drive(1, 18, 4); tick();
    drive(1, 19, 4); tick();
    drive(1, 21, 4);
    wr0_valid = 1'b1; wr0_addr = 15'd600; wr0_data = 8'h99;
    tick();
    drive(1, 22, 4);
    #1;
    chk("pre-reset ram_we", 32'(ram_we), 1);
    chk("pre-reset pix", 32'(pix), 32'h44);
    chk("pre-reset wr0_ready", 32'(wr0_ready), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midframe");
    tick();
    chk("mem[600] untouched", 32'(mem[600]), 32'h33);
    wr0_valid = 1'b0; hsync = 1'b1; vsync = 1'b1;
    drive(1, 0, 0);
    reset = 1'b0;
    tick();
    chk("rerelease ram_addr", 32'(ram_addr), 0);
    chk("rerelease ram_we", 32'(ram_we), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Framebuffer port scheduler between the VGA timing generator and a single-port synchronous framebuffer RAM. It owns the RAM port and reserves one slot every 2^SCALE_LOG2 clocks of active video for scan-out fetch. It grants the remaining slots round-robin to two pixel-write requesters over valid/ready handshakes. It presents the fetched pixel and the sync/blank signals realigned by a fixed 3-cycle pipeline delay.

## Interface
- HACTIVE, 640, active pixels per line (matches timing generator)
- VACTIVE, 480, active lines per frame
- SCALE_LOG2, 2, pixel replication factor log2; FB_W = HACTIVE>>SCALE_LOG2 (160), FB_H = VACTIVE>>SCALE_LOG2 (120)
- AW, 15, RAM address width; FB_W*FB_H must be ≤ 2^AW
- DW, 8, pixel width (RGB332)
- vgaclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- x, y  in  10 each  pixel counters from the timing generator
- hsync, vsync, blank_b  in  1 each  timing generator outputs (sync active-low, blank_b high = visible)
- ram_addr  out  AW  registered RAM address
- ram_we  out  1  registered write enable
- ram_wdata  out  DW  registered write data
- ram_rdata  in  DW  RAM read data, valid one clock after address is presented
- wr0_valid, wr1_valid  in  1 each  write request
- wr0_ready, wr1_ready  out  1 each  grant; transfer occurs in a cycle where valid & ready
- wr0_addr, wr1_addr  in  AW each  linear address (y_fb*FB_W + x_fb)
- wr0_data, wr1_data  in  DW each  pixel value
- pix  out  DW  display pixel; 0 when blank_b_d low
- hsync_d, vsync_d, blank_b_d  out  1 each  inputs delayed 3 cycles
- wr_drop  out  1  one-cycle pulse: accepted write had address ≥ FB_W*FB_H

## Operation
- Fetch slot: cycle with blank_b=1 and x[SCALE_LOG2-1:0]=0. Fetch address = (y>>SCALE_LOG2)*FB_W + (x>>SCALE_LOG2), computed in AW bits, no wrap.
- Free slot: every non-fetch cycle, including all blanking. In a free slot, the arbiter grants exactly one valid requester. wrN_ready is combinational in the same cycle and is never high when wrN_valid is low.
- Round-robin: a 1-bit pointer names the preferred requester. If both are valid, the preferred one is granted and the pointer flips to the other. If only one is valid, it is granted and the pointer is set to the other. No grant leaves the pointer unchanged. Reset pointer = wr0.
- A granted write registers ram_addr/ram_we=1/ram_wdata at the clock edge. Out-of-range address: request is still acked, ram_we stays 0, wr_drop pulses on the next cycle.
- Idle cycle (no fetch, no grant): ram_we=0; ram_addr/ram_wdata hold.
- Fetch: ram_we=0, ram_addr=fetch address registered at the edge. A 2-stage valid shift register tags the return; pix loads ram_rdata when the tag exits, and holds until the next load.
- Reset values: ram_addr=0, ram_we=0, ram_wdata=0, pix=0, hsync_d=1, vsync_d=1, blank_b_d=0, wr_drop=0, both readies 0, fetch tags cleared. Reset mid-transfer discards in-flight fetch/write; no RAM write issues after reset assertion.

## Timing
- Fetch decided in cycle t (x=4k). Address is on the RAM in t+1. rdata is valid in t+2. pix is valid t+3..t+6, aligned with hsync_d/vsync_d/blank_b_d for pixels x=4k..4k+3.
- Write grant in cycle t: RAM command in t+1, memory updated at end of t+1.
- Write bandwidth during active video is 3 of 4 cycles (SCALE_LOG2=2). In blanking it is every cycle.
- A fetch always wins; requester holds valid with stable addr/data until ready.

## Configuration
- FB_WR_BLANK_ONLY_EN defined: free slots restricted to vertical blanking (y ≥ VACTIVE). Readies stay 0 during lines 0..VACTIVE-1, including horizontal blanking, giving tear-free updates.
- Undefined (default): free slots as in Operation.

## Test plan
- Reset asserted mid-frame → all outputs at reset values within same cycle; after release with x=0,y=0 → ram_addr=0, ram_we=0 one cycle later.
- Fetch addressing: x=636,y=479 → ram_addr=19199; x=4,y=4 → ram_addr=161; RAM preloaded with 0x5A at 161 → pix=0x5A for 4 cycles starting 3 cycles after x=4.
- Both requesters valid continuously during blanking → grants alternate wr0,wr1,wr0…; during active video no ready in any x%4=0 cycle.
- Single requester holds valid across fetch cycle x=8 → ready low at x=8, high at x=9, ram_we=1 at x=10 with its addr/data.
- wr0 writes addr 19200 → wr0_ready=1, ram_we stays 0, wr_drop=1 next cycle; RAM contents unchanged.
- With FB_WR_BLANK_ONLY_EN: wr1 valid from y=100 → first ready at y=480,x=0; without macro → ready on first non-fetch cycle.
